// File: rtl/fma_align_pkg.sv
// rtl/fma_align_pkg.sv - shared widths and stage-register flag structs for the FMA align/sum pipe
package fma_align_pkg;

  // Product mantissa width: two integer bits plus 2*NF fraction bits.
  function automatic int calc_np(input int nf);
    return 2 * nf + 2;
  endfunction

  // Sum window: carry bit plus the 3*NF+4 bit alignment window.
  function automatic int calc_ns(input int nf);
    return 3 * nf + 5;
  endfunction

  // Leading-zero count width, wide enough to hold NS itself (all-zero sum).
  function automatic int calc_nl(input int nf);
    return $clog2(3 * nf + 5) + 1;
  endfunction

  // Control flags carried by the alignment stage register.
  typedef struct packed {
    logic ps;           // product sign
    logic zs;           // addend sign
    logic sticky;       // OR of bits dropped from the window
    logic sticky_prod;  // 1: the product carries the sticky bit, 0: the addend
    logic p_live;       // product is nonzero
    logic z_live;       // addend is nonzero
  } s1_t;

  // Control flags carried by the sum stage register.
  typedef struct packed {
    logic ss;
    logic sticky;
    logic zero_result;
  } s2_t;

endpackage

// File: rtl/fma_lzc.sv
// rtl/fma_lzc.sv - combinational leading-zero counter, counts from the MSB
module fma_lzc #(
  parameter int W = 35,
  localparam int LW = $clog2(W) + 1
) (
  input  logic [W-1:0]  vec_i,
  output logic [LW-1:0] count_o
);

  // Scan upward so the highest set bit is the last one to write the count.
  always_comb begin
    count_o = LW'(W);
    for (int i = 0; i < W; i++) begin
      if (vec_i[i]) count_o = LW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fma_align_sum_pipe.sv
// rtl/fma_align_sum_pipe.sv - two-stage align-and-add with sticky, sign and lzc, valid/ready pipelined
module fma_align_sum_pipe
  import fma_align_pkg::*;
#(
  parameter int NE = 5,
  parameter int NF = 10,
  localparam int NP = calc_np(NF),
  localparam int NS = calc_ns(NF),
  localparam int NL = calc_nl(NF)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          ps,
  input  logic          zs,
  input  logic [NE+1:0] pe,
  input  logic [NE-1:0] ze,
  input  logic [NP-1:0] pm,
  input  logic [NF:0]   zm,
  input  logic          p_zero,
  input  logic          z_zero,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [NS-1:0] sm,
  output logic          ss,
  output logic [NE+1:0] se,
  output logic          sticky,
  output logic [NL-1:0] lzc,
  output logic          zero_result
);

  localparam int AW = NS - 1;  // alignment window below the carry bit
  localparam int CW = NE + 3;  // signed shift-count width

  logic s1_valid_q, s2_valid_q;
  logic s2_ready, s1_load, s2_load;

  assign s2_ready = ~s2_valid_q | out_ready;
  assign in_ready = ~s1_valid_q | s2_ready;
  assign s1_load  = in_valid & in_ready;
  assign s2_load  = s1_valid_q & s2_ready;

  // ---------------- Stage 1: alignment ----------------
  logic [CW-1:0]   acnt;
  logic [NF:0]     zm_l;
  logic [NP-1:0]   pm_l;
  logic [AW-1:0]   zvec;
  logic [2*AW-1:0] zwide;

  s1_t             s1_q, s1_d;
  logic [AW-1:0]   s1_add_q, s1_add_d;
  logic [NP-1:0]   s1_prod_q, s1_prod_d;
  logic [NE+1:0]   s1_se_q, s1_se_d;

  assign acnt = {pe[NE+1], pe} - {3'b000, ze} + CW'(NF + 3);

  // Align the addend against the unshifted product and collect the sticky bit.
  always_comb begin
    zm_l  = z_zero ? '0 : zm;
    pm_l  = p_zero ? '0 : pm;
    zvec  = {zm_l, {(2*NF+3){1'b0}}};
    // The low half of the double-width shift holds exactly the bits pushed out.
    zwide = {zvec, {AW{1'b0}}} >> acnt;

    s1_d.ps     = ps;
    s1_d.zs     = zs;
    s1_d.p_live = ~p_zero;
    s1_d.z_live = ~z_zero;

    if (acnt[CW-1]) begin
      // Addend dominates: whole product collapses into sticky.
      s1_add_d         = zvec;
      s1_prod_d        = '0;
      s1_d.sticky      = |pm_l;
      s1_d.sticky_prod = 1'b1;
      s1_se_d          = {2'b00, ze};
    end else if (acnt > CW'(AW)) begin
      // Addend shifted entirely out of the window.
      s1_add_d         = '0;
      s1_prod_d        = pm_l;
      s1_d.sticky      = |zm_l;
      s1_d.sticky_prod = 1'b0;
      s1_se_d          = pe;
    end else begin
      s1_add_d         = zwide[2*AW-1:AW];
      s1_prod_d        = pm_l;
      s1_d.sticky      = |zwide[AW-1:0];
      s1_d.sticky_prod = 1'b0;
      s1_se_d          = pe;
    end
  end

  // Stage 1 register: valid follows the handshake, data loads only on a transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s1_add_q   <= '0;
      s1_prod_q  <= '0;
      s1_se_q    <= '0;
    end else begin
      if (in_ready) s1_valid_q <= in_valid;
      if (s1_load) begin
        s1_q      <= s1_d;
        s1_add_q  <= s1_add_d;
        s1_prod_q <= s1_prod_d;
        s1_se_q   <= s1_se_d;
      end
    end
  end

  // ---------------- Stage 2: signed sum ----------------
  logic [NS-1:0] a_x, p_x, s2_sm_d, s2_sm_q;
  logic          eff_sub, add_big, borrow, zero_d, ss_d;
  logic [NL-1:0] s2_lzc_d, s2_lzc_q;
  logic [NE+1:0] s2_se_q;
  s2_t           s2_q, s2_d;

  // Magnitude add/subtract; a sticky subtrahend costs one extra LSB.
  always_comb begin
    a_x     = {1'b0, s1_add_q};
    p_x     = {{(NS-NP){1'b0}}, s1_prod_q};
    eff_sub = (s1_q.ps ^ s1_q.zs) & s1_q.p_live & s1_q.z_live;
    // On an exact window tie the operand that also owns the sticky bits is larger.
    add_big = (a_x > p_x) | ((a_x == p_x) & s1_q.sticky & ~s1_q.sticky_prod);
    borrow  = s1_q.sticky & (add_big ? s1_q.sticky_prod : ~s1_q.sticky_prod);
    if (eff_sub) begin
      s2_sm_d = (add_big ? a_x - p_x : p_x - a_x) - NS'(borrow);
      ss_d    = add_big ? s1_q.zs : s1_q.ps;
    end else begin
      s2_sm_d = a_x + p_x;
      ss_d    = s1_q.ps;
    end
    zero_d = (s2_sm_d == '0) & ~s1_q.sticky;
    if (zero_d) ss_d = s1_q.ps & s1_q.zs;

    s2_d.ss          = ss_d;
    s2_d.sticky      = s1_q.sticky;
    s2_d.zero_result = zero_d;
  end

  fma_lzc #(.W(NS)) u_lzc (
    .vec_i   (s2_sm_d),
    .count_o (s2_lzc_d)
  );

  // Stage 2 register drives the outputs directly and holds while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_q <= 1'b0;
      s2_q       <= '0;
      s2_sm_q    <= '0;
      s2_se_q    <= '0;
      s2_lzc_q   <= '0;
    end else begin
      if (s2_ready) s2_valid_q <= s1_valid_q;
      if (s2_load) begin
        s2_q     <= s2_d;
        s2_sm_q  <= s2_sm_d;
        s2_se_q  <= s1_se_q;
        s2_lzc_q <= s2_lzc_d;
      end
    end
  end

  assign out_valid   = s2_valid_q;
  assign sm          = s2_sm_q;
  assign ss          = s2_q.ss;
  assign se          = s2_se_q;
  assign sticky      = s2_q.sticky;
  assign lzc         = s2_lzc_q;
  assign zero_result = s2_q.zero_result;

endmodule
